digimark_seq: RTL and testbench
===============================

# digimark_seq

Multi-channel, parametrised digital marker generator for the qubic timing fabric. Each channel accepts a 64-bit marker command, then emits a gated pulse window on its `mark` bit. Windows are one-shot or periodic with a repeat count, and can optionally wait for a shared trigger. Channels are independent and share the command bus; outputs feed scope/debug markers and downstream gating.

## Interface
Parameters:
- `NCHAN`, 4: number of independent marker channels (1..16).
- `TW`, 12: width of the start/length/period fields (1..12). Each field occupies the low `TW` bits of its 12-bit slot; the upper slot bits are ignored.

Ports:
- `clk`  in  1  single clock; everything is synchronous to its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cstrobe`  in  NCHAN  per-channel command strobe; bit i loads `command` into channel i.
- `command`  in  64  marker command; sampled only when a `cstrobe` bit is high.
- `trig`  in  1  shared start trigger for channels that are armed.
- `mark`  out  NCHAN  registered marker outputs, XOR-ed with each channel's invert bit.
- `busy`  out  NCHAN  high while the channel is ARMED or RUN; decoded directly from the state register.

## Operation
Command fields:
- [63] abort
- [62] invert
- [61:50] start
- [49:38] length
- [37:26] period (0 = one-shot)
- [25:18] count (0 = infinite when period≠0)
- [17] wait_trig
- remaining bits are ignored

Per-channel state is IDLE/ARMED/RUN, with a counter `cnt` (TW+1 bits) and a repeat counter `rep` (8 bits).

Strobe at edge E (`cstrobe[i]` high), non-abort:
- Latch start, length, period, count, invert.
- Set `cnt` to 0 and `rep` to count.
- Next state is ARMED if wait_trig=1, otherwise RUN.
- This applies from any state; a strobe in RUN restarts with the new fields.

Strobe with abort=1:
- State goes to IDLE and `cnt` to 0.
- All other fields are ignored; invert is retained.

ARMED:
- `cnt` is held at 0.
- On an edge with `trig`=1 and no strobe to that channel, the state goes to RUN.
- `trig` in the same cycle as the loading strobe is ignored, because the channel is not yet ARMED.

RUN:
- Window: win = (`cnt` ≥ start) and (`cnt` < start+length) and (period=0 or `cnt` < period). Sums are TW+1 bits and never wrap.
- One-shot (period=0): `cnt` increments each cycle. When `cnt` = start+length, the next state is IDLE.
- Periodic: when `cnt` = period−1:
  - if count=0, `cnt` goes to 0;
  - else if `rep`=1, the next state is IDLE;
  - else `rep` decrements and `cnt` goes to 0.
  - Otherwise `cnt` increments.
- length=0 gives no pulse, but the channel still runs to completion.
- start ≥ period gives no pulse, but counting continues.
- If start+length > period, the window is truncated at period−1.

Output: mark_r ← (state=RUN) and win. Then `mark`[i] = mark_r ^ invert. In IDLE/ARMED, `mark` equals the invert level.

Priority per channel: `rst` > strobe (abort or load) > `trig` > normal counting.

## Timing
- Reset values: state IDLE, `cnt`=0, `rep`=0, mark_r=0, invert=0. Therefore `mark`=0 and `busy`=0 immediately on `rst`, without waiting for a clock edge.
- Reset asserted mid-pulse clears `mark` asynchronously; the channel does nothing until the next strobe.
- Strobe in cycle T: `busy` is high from T+1 and `cnt`=0 in T+1.
- Non-trig channel: `mark` rises in cycle T+2+start and is high for min(length, period−start) cycles.
- Triggered channel: `trig` high in cycle U gives `cnt`=0 in U+1 and `mark` rising at U+2+start.
- One-shot: `busy` falls at cycle T+2+start+length.
- Abort in cycle A: `busy` and mark_r are low from A+1.
- A command latches only on strobe bits that are set; other channels are unaffected.

## Test plan
- Reset/idle: assert `rst` asynchronously while `mark` is high → `mark`=0 and `busy`=0 with no clock edge; outputs stay 0 after release until a strobe arrives.
- One-shot, ch0: strobe at cycle 0 with start=3, length=2, period=0 → `mark[0]` high in cycles 5–6, low in cycle 7; `busy[0]` high in cycles 1–6; `mark[3:1]` stay 0.
- Periodic, ch1: start=1, length=2, period=5, count=3 → `mark[1]` high in cycles 3–4, 8–9, 13–14; `busy` falls at cycle 16. Same setup with start=3, length=5, period=6, count=2 → 3-cycle pulses (truncated).
- Trigger/abort, ch2: wait_trig=1, start=0, length=4; `trig` at cycle 10 → `mark[2]` high in cycles 12–15. `trig` in the strobe cycle is ignored. Abort at cycle 13 → `mark` low and `busy` low from cycle 14.
- Invert/restart, ch3: invert=1, start=2, length=3 → `mark[3]` idles at 1 and goes low for the window. A restart strobe mid-window reloads the fields and `cnt` restarts at 0.
- Boundaries: length=0 → no pulse, `busy` for start+1 cycles. start=4095, length=4095 → sum reaches 8190 without wrap. Simultaneous strobes to all channels → identical independent outputs.

Source files
------------

// File: rtl/digimark_seq_if.sv
// rtl/digimark_seq_if.sv - command bus and marker outputs shared by all channels
interface digimark_seq_if #(
  parameter int NCHAN = 4
);
  logic [NCHAN-1:0] cstrobe;
  logic [63:0]      command;
  logic             trig;
  logic [NCHAN-1:0] mark;
  logic [NCHAN-1:0] busy;

  modport master (
    output cstrobe, command, trig,
    input  mark, busy
  );

  modport slave (
    input  cstrobe, command, trig,
    output mark, busy
  );
endinterface

// File: rtl/digimark_seq.sv
// rtl/digimark_seq.sv - multi-channel marker generator: one-shot or periodic pulse
// windows per channel, optionally armed on a shared trigger.
module digimark_seq #(
  parameter int NCHAN = 4,
  parameter int TW    = 12
) (
  input logic          clk,
  input logic          rst,
  digimark_seq_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam logic [TW:0] ONE = (TW + 1)'(1);

  logic             cmd_abort;
  logic             cmd_invert;
  logic [TW-1:0]    cmd_start;
  logic [TW-1:0]    cmd_length;
  logic [TW-1:0]    cmd_period;
  logic [7:0]       cmd_count;
  logic             cmd_wait;
  logic [NCHAN-1:0] mark_v;
  logic [NCHAN-1:0] busy_v;
  logic             unused_cmd;

  assign cmd_abort  = bus.command[63];
  assign cmd_invert = bus.command[62];
  assign cmd_start  = bus.command[50 +: TW];
  assign cmd_length = bus.command[38 +: TW];
  assign cmd_period = bus.command[26 +: TW];
  assign cmd_count  = bus.command[25:18];
  assign cmd_wait   = bus.command[17];
  assign unused_cmd = ^bus.command;

  for (genvar i = 0; i < NCHAN; i++) begin : g_chan
    state_t        state, state_n;
    logic [TW:0]   cnt, cnt_n;
    logic [7:0]    rep, rep_n;
    logic          mark_r, mark_n;
    logic [TW-1:0] start, length, period;
    logic [7:0]    count;
    logic          invert;
    logic          strobe;
    logic [TW:0]   win_end;
    logic          win;
    logic          period_end;

    assign strobe     = bus.cstrobe[i];
    assign win_end    = {1'b0, start} + {1'b0, length};
    assign win        = (cnt >= {1'b0, start}) && (cnt < win_end) &&
                        ((period == '0) || (cnt < {1'b0, period}));
    assign period_end = (cnt == ({1'b0, period} - ONE));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state  <= IDLE;
        cnt    <= '0;
        rep    <= '0;
        mark_r <= 1'b0;
      end else begin
        state  <= state_n;
        cnt    <= cnt_n;
        rep    <= rep_n;
        mark_r <= mark_n;
      end
    end

    // Abort leaves every field, including invert, untouched.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        start  <= '0;
        length <= '0;
        period <= '0;
        count  <= '0;
        invert <= 1'b0;
      end else if (strobe && !cmd_abort) begin
        start  <= cmd_start;
        length <= cmd_length;
        period <= cmd_period;
        count  <= cmd_count;
        invert <= cmd_invert;
      end
    end

    always_comb begin
      state_n = state;
      cnt_n   = cnt;
      rep_n   = rep;
      mark_n  = 1'b0;
      if (strobe) begin
        cnt_n = '0;
        if (cmd_abort) begin
          state_n = IDLE;
        end else begin
          state_n = cmd_wait ? ARMED : RUN;
          rep_n   = cmd_count;
        end
      end else begin
        case (state)
          ARMED: begin
            cnt_n = '0;
            if (bus.trig) state_n = RUN;
          end
          RUN: begin
            mark_n = win;
            if (period == '0) begin
              if (cnt == win_end) begin
                state_n = IDLE;
                cnt_n   = '0;
              end else begin
                cnt_n = cnt + ONE;
              end
            end else if (period_end) begin
              // count of zero repeats forever; otherwise rep counts down the periods left
              if (count == 8'd0) begin
                cnt_n = '0;
              end else if (rep == 8'd1) begin
                state_n = IDLE;
                cnt_n   = '0;
              end else begin
                rep_n = rep - 8'd1;
                cnt_n = '0;
              end
            end else begin
              cnt_n = cnt + ONE;
            end
          end
          default: ;
        endcase
      end
    end

    assign mark_v[i] = mark_r ^ invert;
    assign busy_v[i] = (state == ARMED) || (state == RUN);
  end

  assign bus.mark = mark_v;
  assign bus.busy = busy_v;
endmodule

// File: tb/tb_digimark_seq.sv
// tb/tb_digimark_seq.sv - directed scoreboard bench for digimark_seq
module tb_digimark_seq;
  localparam int NCHAN = 4;
  localparam int PMAX  = 8300;

  logic clk;
  logic rst;
  digimark_seq_if #(.NCHAN(NCHAN)) bus ();

  digimark_seq #(.NCHAN(NCHAN), .TW(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  string tname;

  logic [NCHAN-1:0] exp_m  [0:PMAX-1];
  logic [NCHAN-1:0] exp_b  [0:PMAX-1];
  logic [NCHAN-1:0] st_cs  [0:PMAX-1];
  logic [63:0]      st_cmd [0:PMAX-1];
  logic             st_trig[0:PMAX-1];
  logic [NCHAN-1:0] cur_inv;
  logic [NCHAN-1:0] em_q[$];
  logic [NCHAN-1:0] eb_q[$];

  function automatic logic [63:0] mk_cmd(input bit ab, input bit inv, input int s, input int l,
                                         input int p, input int n_rep, input bit wt);
    logic [63:0] r;
    r        = 64'h0;
    r[63]    = ab;
    r[62]    = inv;
    r[61:50] = s[11:0];
    r[49:38] = l[11:0];
    r[37:26] = p[11:0];
    r[25:18] = n_rep[7:0];
    r[17]    = wt;
    r[16:0]  = 17'h1A5A5;
    return r;
  endfunction

  task automatic clear_plan(input int n);
    for (int c = 0; c < n; c++) begin
      exp_m[c]   = cur_inv;
      exp_b[c]   = '0;
      st_cs[c]   = '0;
      st_cmd[c]  = 64'h0;
      st_trig[c] = 1'b0;
    end
  endtask

  // Expected trace from the documented timing: cnt=0 one cycle after the
  // strobe (or trigger), mark one cycle after cnt enters the window.
  task automatic plan_run(input int ch, input int t0, input int u, input int s, input int l,
                          input int p, input int n_rep, input bit inv, input bit wt, input int n);
    int b;
    int last;
    int hi;
    b = wt ? u : t0;
    st_cs[t0][ch] = 1'b1;
    st_cmd[t0]    = mk_cmd(1'b0, inv, s, l, p, n_rep, wt);
    if (wt) st_trig[u] = 1'b1;
    last = (p == 0) ? (b + 1 + s + l) : (b + n_rep * p);
    for (int c = t0 + 1; c < n; c++) begin
      exp_m[c][ch] = inv;
      exp_b[c][ch] = (c <= last);
    end
    if (p == 0) begin
      for (int j = s; j < s + l; j++)
        if (b + 2 + j < n) exp_m[b + 2 + j][ch] = ~inv;
    end else begin
      hi = (s + l < p) ? (s + l) : p;
      for (int k = 0; k < n_rep; k++)
        for (int j = s; j < hi; j++)
          if (b + 2 + k * p + j < n) exp_m[b + 2 + k * p + j][ch] = ~inv;
    end
    cur_inv[ch] = inv;
  endtask

  task automatic plan_abort(input int ch, input int t, input int n);
    st_cs[t][ch] = 1'b1;
    st_cmd[t]    = mk_cmd(1'b1, ~cur_inv[ch], 5, 5, 0, 0, 1'b0);
    for (int c = t + 1; c < n; c++) begin
      exp_m[c][ch] = cur_inv[ch];
      exp_b[c][ch] = 1'b0;
    end
  endtask

  task automatic run_plan(input int n);
    logic [NCHAN-1:0] em;
    logic [NCHAN-1:0] eb;
    for (int c = 0; c < n; c++) begin
      bus.cstrobe = st_cs[c];
      bus.command = st_cmd[c];
      bus.trig    = st_trig[c];
      em_q.push_back(exp_m[c]);
      eb_q.push_back(exp_b[c]);
      @(negedge clk);
      em = em_q.pop_front();
      eb = eb_q.pop_front();
      checks++;
      assert (bus.mark === em) else begin
        errors++;
        $error("FAIL %s mark cycle %0d observed %b expected %b", tname, c, bus.mark, em);
      end
      checks++;
      assert (bus.busy === eb) else begin
        errors++;
        $error("FAIL %s busy cycle %0d observed %b expected %b", tname, c, bus.busy, eb);
      end
      @(posedge clk);
      #1;
    end
    bus.cstrobe = '0;
    bus.command = 64'h0;
    bus.trig    = 1'b0;
  endtask

  initial begin
    cur_inv     = '0;
    rst         = 1'b1;
    bus.cstrobe = '0;
    bus.command = 64'h0;
    bus.trig    = 1'b0;
    #1;
    tname = "reset";
    checks++;
    assert (bus.mark === 4'b0000) else begin
      errors++;
      $error("FAIL %s mark observed %b expected 0000", tname, bus.mark);
    end
    checks++;
    assert (bus.busy === 4'b0000) else begin
      errors++;
      $error("FAIL %s busy observed %b expected 0000", tname, bus.busy);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    tname = "idle";
    clear_plan(4);
    run_plan(4);

    tname = "oneshot";
    clear_plan(10);
    plan_run(0, 0, 0, 3, 2, 0, 0, 1'b0, 1'b0, 10);
    run_plan(10);

    tname = "periodic";
    clear_plan(20);
    plan_run(1, 0, 0, 1, 2, 5, 3, 1'b0, 1'b0, 20);
    run_plan(20);

    tname = "periodic_trunc";
    clear_plan(16);
    plan_run(1, 0, 0, 3, 5, 6, 2, 1'b0, 1'b0, 16);
    run_plan(16);

    tname = "trig";
    clear_plan(20);
    plan_run(2, 0, 10, 0, 4, 0, 0, 1'b0, 1'b1, 20);
    st_trig[0] = 1'b1;
    run_plan(20);

    tname = "trig_abort";
    clear_plan(20);
    plan_run(2, 0, 10, 0, 4, 0, 0, 1'b0, 1'b1, 20);
    st_trig[0] = 1'b1;
    plan_abort(2, 13, 20);
    run_plan(20);

    tname = "invert_restart";
    clear_plan(14);
    plan_run(3, 0, 0, 2, 3, 0, 0, 1'b1, 1'b0, 14);
    plan_run(3, 5, 5, 1, 2, 0, 0, 1'b1, 1'b0, 14);
    run_plan(14);

    tname = "abort_keeps_invert";
    clear_plan(5);
    plan_abort(3, 1, 5);
    run_plan(5);

    tname = "len_zero";
    clear_plan(8);
    plan_run(0, 0, 0, 2, 0, 0, 0, 1'b0, 1'b0, 8);
    run_plan(8);

    tname = "max_fields";
    clear_plan(8200);
    plan_run(1, 0, 0, 4095, 4095, 0, 0, 1'b0, 1'b0, 8200);
    run_plan(8200);

    tname = "all_channels";
    clear_plan(14);
    for (int ch = 0; ch < NCHAN; ch++)
      plan_run(ch, 0, 0, 1, 3, 4, 2, 1'b0, 1'b0, 14);
    run_plan(14);

    tname = "async_reset";
    clear_plan(6);
    plan_run(0, 0, 0, 0, 100, 0, 0, 1'b0, 1'b0, 6);
    run_plan(6);
    checks++;
    assert (bus.mark === 4'b0001) else begin
      errors++;
      $error("FAIL %s pre-reset mark observed %b expected 0001", tname, bus.mark);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    assert (bus.mark === 4'b0000) else begin
      errors++;
      $error("FAIL %s mark observed %b expected 0000", tname, bus.mark);
    end
    checks++;
    assert (bus.busy === 4'b0000) else begin
      errors++;
      $error("FAIL %s busy observed %b expected 0000", tname, bus.busy);
    end
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    cur_inv = '0;
    tname = "post_reset_idle";
    clear_plan(6);
    run_plan(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
